// File: rtl/nametable_wr_if.sv
// -----------------------------------------------------------------------------
// nametable_wr_if
//   Bundles every bus signal of the nametable/attribute RAM write arbiter:
//   the buffered CPU write port with its FIFO status and overflow flag, the
//   scroll engine valid/ready write port, the registered RAM write port and
//   the busy indicator.
//
//   modport slave  : the arbiter's view (requests in, RAM port/status out)
//   modport master : the requesters' / RAM side view (the opposite direction)
//
//   Parameter FIFO_DEPTH must match the arbiter instance; it sizes
//   cpu_fifo_level ($clog2(FIFO_DEPTH)+1 bits, so the value FIFO_DEPTH fits).
// -----------------------------------------------------------------------------
interface nametable_wr_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // CPU write path
  logic             cpu_wr_en;
  logic             cpu_wr_sel;      // 0 = nametable, 1 = attribute table
  logic [3:0]       cpu_wr_be;
  logic [8:0]       cpu_wr_addr;
  logic [31:0]      cpu_wr_data;
  logic             cpu_fifo_full;
  logic [LVL_W-1:0] cpu_fifo_level;
  logic             cpu_overflow;
  logic             ovf_clr;

  // Scroll engine copy path
  logic             scr_valid;
  logic             scr_ready;
  logic             scr_sel;
  logic [3:0]       scr_be;
  logic [8:0]       scr_addr;
  logic [31:0]      scr_data;

  // RAM write port
  logic [3:0]       ram_name_we;
  logic [3:0]       ram_attr_we;
  logic [8:0]       ram_addr;
  logic [31:0]      ram_wdata;

  logic             busy;

  modport slave (
    input  cpu_wr_en, cpu_wr_sel, cpu_wr_be, cpu_wr_addr, cpu_wr_data, ovf_clr,
    input  scr_valid, scr_sel, scr_be, scr_addr, scr_data,
    output cpu_fifo_full, cpu_fifo_level, cpu_overflow,
    output scr_ready,
    output ram_name_we, ram_attr_we, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output cpu_wr_en, cpu_wr_sel, cpu_wr_be, cpu_wr_addr, cpu_wr_data, ovf_clr,
    output scr_valid, scr_sel, scr_be, scr_addr, scr_data,
    input  cpu_fifo_full, cpu_fifo_level, cpu_overflow,
    input  scr_ready,
    input  ram_name_we, ram_attr_we, ram_addr, ram_wdata,
    input  busy
  );
endinterface

// File: rtl/nametable_wr_arbiter.sv
// -----------------------------------------------------------------------------
// nametable_wr_arbiter
//   Shares the single nametable/attribute RAM write port between the CPU
//   write path (buffered in a small FIFO) and the scroll engine's
//   flash-to-nametable copy (valid/ready, no storage here).
//
//   Scroll traffic wins by default. While CPU entries wait, at most
//   STARVE_MAX consecutive scroll grants are given before one CPU entry is
//   forced out, so the CPU FIFO always drains.
//
//   The winner of each cycle is loaded into the RAM output register, so a
//   granted write appears on ram_* exactly one cycle after its grant.
//
// Ports
//   clk  : 100 MHz clock
//   rstn : asynchronous active-low reset
//   bus  : nametable_wr_if.slave
//          cpu_wr_*        CPU write strobe/target/enables/address/data
//          cpu_fifo_full   FIFO count == FIFO_DEPTH
//          cpu_fifo_level  current FIFO count
//          cpu_overflow    sticky: a CPU write was dropped (ovf_clr clears)
//          scr_*           scroll request; scr_ready is combinational
//          ram_*           registered RAM write port
//          busy            scroll request, FIFO non-empty or write in flight
// -----------------------------------------------------------------------------
module nametable_wr_arbiter #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int STARVE_MAX = 8    // max consecutive scroll grants vs waiting CPU
) (
  input logic           clk,
  input logic           rstn,
  nametable_wr_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_SCR,
    OWN_CPU
  } owner_e;

  typedef struct packed {
    logic        sel;
    logic [3:0]  be;
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_req_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LVL_W-1:0] count_q,   count_d;
  logic             ovf_q,     ovf_d;
  logic [STV_W-1:0] starve_q,  starve_d;
  owner_e           owner_q,   owner_d;
  logic [3:0]       name_we_q, name_we_d;
  logic [3:0]       attr_we_q, attr_we_d;
  logic [8:0]       addr_q,    addr_d;
  logic [31:0]      wdata_q,   wdata_d;

  // Combinational helpers
  logic    fifo_ne;
  logic    fifo_full;
  logic    push;
  logic    drop;
  logic    pop;
  wr_req_t cpu_req;
  wr_req_t head_req;
  wr_req_t win_req;

  assign cpu_req  = '{sel:  bus.cpu_wr_sel,
                      be:   bus.cpu_wr_be,
                      addr: bus.cpu_wr_addr,
                      data: bus.cpu_wr_data};
  assign head_req = fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    owner_d   = OWN_IDLE;
    starve_d  = starve_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    name_we_d = '0;
    attr_we_d = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    win_req   = head_req;

    // Fullness is judged on the registered count, before any same-cycle pop:
    // a write that arrives while full is dropped even if an entry leaves now.
    fifo_ne   = (count_q != '0);
    fifo_full = (count_q == LVL_W'(FIFO_DEPTH));
    push      = bus.cpu_wr_en && !fifo_full;
    drop      = bus.cpu_wr_en &&  fifo_full;

    // Owner decision: starvation limit first, then scroll, then CPU.
    if (fifo_ne && (starve_q == STV_W'(STARVE_MAX))) begin
      owner_d = OWN_CPU;
    end else if (bus.scr_valid) begin
      owner_d = OWN_SCR;
    end else if (fifo_ne) begin
      owner_d = OWN_CPU;
    end

    pop = (owner_d == OWN_CPU);

    // Starvation counter only tracks scroll grants that keep the CPU waiting.
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if ((owner_d == OWN_SCR) && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end

    // FIFO bookkeeping; pointers wrap naturally because the depth is 2^PTR_W.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + LVL_W'(push) - LVL_W'(pop);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end

    // Output register load. An idle cycle only drops the enables; address
    // and data keep their last value.
    if (owner_d == OWN_SCR) begin
      win_req = '{sel:  bus.scr_sel,
                  be:   bus.scr_be,
                  addr: bus.scr_addr,
                  data: bus.scr_data};
    end
    if (owner_d != OWN_IDLE) begin
      name_we_d = win_req.sel ? 4'b0000   : win_req.be;
      attr_we_d = win_req.sel ? win_req.be : 4'b0000;
      addr_d    = win_req.addr;
      wdata_d   = win_req.data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (!rstn) begin
      owner_q   <= OWN_IDLE;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      name_we_q <= '0;
      attr_we_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      name_we_q <= name_we_d;
      attr_we_q <= attr_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only ever read after it
  // was written, and the cleared count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cpu_req;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // scr_ready and busy are gated with rstn so a held scroll request is never
  // accepted, nor reported, while the block is in reset.
  assign bus.scr_ready      = rstn && (owner_d == OWN_SCR);
  assign bus.busy           = rstn && (bus.scr_valid || fifo_ne || (owner_q != OWN_IDLE));
  assign bus.cpu_fifo_full  = fifo_full;
  assign bus.cpu_fifo_level = count_q;
  assign bus.cpu_overflow   = ovf_q;
  assign bus.ram_name_we    = name_we_q;
  assign bus.ram_attr_we    = attr_we_q;
  assign bus.ram_addr       = addr_q;
  assign bus.ram_wdata      = wdata_q;

endmodule

// File: tb/tb_nametable_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nametable_wr_arbiter
//   Directed bench for nametable_wr_arbiter (FIFO_DEPTH=4, STARVE_MAX=8).
//   Inputs change and registered outputs are sampled 1 ns after each rising
//   edge; the combinational scr_ready is sampled 1 ns after the inputs move.
//   Expected values are hand-derived constants for each step.
// -----------------------------------------------------------------------------
module tb_nametable_wr_arbiter;

  logic clk;
  logic rstn;

  int compared   = 0;
  int mismatched = 0;

  nametable_wr_if #(.FIFO_DEPTH(4)) bus ();

  nametable_wr_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both enable vectors must never be active together.
  always @(negedge clk) begin
    if (rstn) check("one_we", {63'b0, (|bus.ram_name_we) && (|bus.ram_attr_we)}, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn           = 1'b0;
    bus.cpu_wr_en  = 1'b0;
    bus.cpu_wr_sel = 1'b0;
    bus.cpu_wr_be  = 4'h0;
    bus.cpu_wr_addr= 9'h000;
    bus.cpu_wr_data= 32'h0;
    bus.ovf_clr    = 1'b0;
    bus.scr_valid  = 1'b1;   // held request must not be accepted in reset
    bus.scr_sel    = 1'b0;
    bus.scr_be     = 4'hF;
    bus.scr_addr   = 9'h100;
    bus.scr_data   = 32'h5C50_0000;

    // ---------------- reset state ----------------
    #2;
    check("rst_name_we", bus.ram_name_we, 0);
    check("rst_attr_we", bus.ram_attr_we, 0);
    check("rst_addr",    bus.ram_addr, 0);
    check("rst_wdata",   bus.ram_wdata, 0);
    check("rst_level",   bus.cpu_fifo_level, 0);
    check("rst_full",    bus.cpu_fifo_full, 0);
    check("rst_ovf",     bus.cpu_overflow, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_ready",   bus.scr_ready, 0);
    bus.scr_valid = 1'b0;
    #10 rstn = 1'b1;
    step();

    // ---------------- single CPU write ----------------
    bus.cpu_wr_en   = 1'b1;
    bus.cpu_wr_sel  = 1'b1;
    bus.cpu_wr_be   = 4'hF;
    bus.cpu_wr_addr = 9'h012;
    bus.cpu_wr_data = 32'hA5A5_0001;
    step();
    bus.cpu_wr_en = 1'b0;
    check("single_level1", bus.cpu_fifo_level, 1);
    check("single_we_early", bus.ram_attr_we, 0);
    step();
    check("single_attr_we", bus.ram_attr_we, 4'hF);
    check("single_name_we", bus.ram_name_we, 4'h0);
    check("single_addr",    bus.ram_addr, 9'h012);
    check("single_data",    bus.ram_wdata, 32'hA5A5_0001);
    check("single_level0",  bus.cpu_fifo_level, 0);
    check("single_busy",    bus.busy, 1);
    step();
    check("idle_attr_we",   bus.ram_attr_we, 4'h0);
    check("idle_addr_hold", bus.ram_addr, 9'h012);
    check("idle_data_hold", bus.ram_wdata, 32'hA5A5_0001);
    check("idle_busy",      bus.busy, 0);

    // ---------------- starvation limit ----------------
    // Three CPU writes in cycles 0..2 under continuous scroll traffic:
    // the limit forces CPU grants in cycles 9, 18 and 27.
    bus.scr_sel  = 1'b0;
    bus.scr_be   = 4'hF;
    bus.scr_addr = 9'h100;
    bus.scr_data = 32'h5C50_0100;
    for (int c = 0; c < 30; c++) begin
      bus.scr_valid   = 1'b1;
      bus.cpu_wr_en   = (c < 3);
      bus.cpu_wr_sel  = 1'b1;
      bus.cpu_wr_be   = 4'hF;
      bus.cpu_wr_addr = 9'(32'h020 + c);
      bus.cpu_wr_data = 32'hC000_0000 + c;
      if (c == 10 || c == 19 || c == 28) begin
        check($sformatf("starve_cpu_we_c%0d", c), bus.ram_attr_we, 4'hF);
        check($sformatf("starve_cpu_addr_c%0d", c), bus.ram_addr,
              (c == 10) ? 9'h020 : (c == 19) ? 9'h021 : 9'h022);
      end else if (c > 0) begin
        check($sformatf("starve_scr_we_c%0d", c), bus.ram_name_we, 4'hF);
        check($sformatf("starve_scr_addr_c%0d", c), bus.ram_addr, 9'h100);
      end
      #1;
      check($sformatf("starve_ready_c%0d", c), bus.scr_ready,
            (c == 9 || c == 18 || c == 27) ? 1'b0 : 1'b1);
      step();
    end
    bus.scr_valid = 1'b0;
    bus.cpu_wr_en = 1'b0;
    step();
    step();
    check("starve_level_end", bus.cpu_fifo_level, 0);

    // ---------------- overflow ----------------
    // Scroll hogs the port while six CPU writes arrive; writes 5 and 6 are
    // dropped. ovf_clr in the first drop cycle loses to the set.
    for (int c = 0; c < 12; c++) begin
      bus.scr_valid   = (c < 7);
      bus.cpu_wr_en   = (c < 6);
      bus.cpu_wr_sel  = 1'b1;
      bus.cpu_wr_be   = 4'hF;
      bus.cpu_wr_addr = 9'(32'h040 + c);
      bus.cpu_wr_data = 32'hD000_0000 + c;
      bus.ovf_clr     = (c == 4 || c == 6);
      if (c == 4) begin
        check("ovf_before_drop", bus.cpu_overflow, 0);
        check("ovf_full_c4", bus.cpu_fifo_full, 1);
      end
      if (c == 5) begin
        check("ovf_set_wins", bus.cpu_overflow, 1);
        check("ovf_full_c5",  bus.cpu_fifo_full, 1);
        check("ovf_level_c5", bus.cpu_fifo_level, 4);
      end
      if (c == 6) check("ovf_held", bus.cpu_overflow, 1);
      if (c == 7) check("ovf_cleared", bus.cpu_overflow, 0);
      if (c >= 8) begin
        check($sformatf("ovf_drain_we_c%0d", c), bus.ram_attr_we, 4'hF);
        check($sformatf("ovf_drain_addr_c%0d", c), bus.ram_addr, 9'(32'h040 + c - 8));
        check($sformatf("ovf_drain_data_c%0d", c), bus.ram_wdata, 32'hD000_0000 + c - 8);
      end
      step();
    end
    bus.ovf_clr = 1'b0;
    check("ovf_level_end", bus.cpu_fifo_level, 0);
    check("ovf_full_end",  bus.cpu_fifo_full, 0);
    check("ovf_idle_we",   bus.ram_attr_we, 4'h0);

    // ---------------- partial enables ----------------
    bus.scr_valid = 1'b1;
    bus.scr_sel   = 1'b0;
    bus.scr_be    = 4'b0011;
    bus.scr_addr  = 9'h0AA;
    bus.scr_data  = 32'h1234_5678;
    #1;
    check("be_scr_ready", bus.scr_ready, 1);
    step();
    bus.scr_valid = 1'b0;
    check("be_scr_name_we", bus.ram_name_we, 4'b0011);
    check("be_scr_attr_we", bus.ram_attr_we, 4'b0000);
    check("be_scr_addr",    bus.ram_addr, 9'h0AA);
    bus.cpu_wr_en   = 1'b1;
    bus.cpu_wr_sel  = 1'b0;
    bus.cpu_wr_be   = 4'b0000;
    bus.cpu_wr_addr = 9'h0BB;
    bus.cpu_wr_data = 32'h0000_0BBB;
    step();
    bus.cpu_wr_en = 1'b0;
    step();
    check("be0_name_we", bus.ram_name_we, 4'b0000);
    check("be0_attr_we", bus.ram_attr_we, 4'b0000);
    check("be0_addr",    bus.ram_addr, 9'h0BB);
    check("be0_busy",    bus.busy, 1);
    check("be0_level",   bus.cpu_fifo_level, 0);
    step();

    // ---------------- mid-traffic reset ----------------
    bus.scr_valid   = 1'b1;
    bus.scr_sel     = 1'b1;
    bus.scr_be      = 4'hF;
    bus.scr_addr    = 9'h1FF;
    bus.scr_data    = 32'hFFFF_0000;
    bus.cpu_wr_en   = 1'b1;
    bus.cpu_wr_sel  = 1'b0;
    bus.cpu_wr_be   = 4'hF;
    bus.cpu_wr_addr = 9'h0CC;
    bus.cpu_wr_data = 32'h0000_0CCC;
    step();
    bus.cpu_wr_en = 1'b0;
    step();
    check("mrst_pre_attr_we", bus.ram_attr_we, 4'hF);
    check("mrst_pre_level",   bus.cpu_fifo_level, 1);
    #2 rstn = 1'b0;
    #1;
    check("mrst_attr_we", bus.ram_attr_we, 4'h0);
    check("mrst_name_we", bus.ram_name_we, 4'h0);
    check("mrst_level",   bus.cpu_fifo_level, 0);
    check("mrst_busy",    bus.busy, 0);
    check("mrst_ready",   bus.scr_ready, 0);
    step();
    check("mrst_ready_hold", bus.scr_ready, 0);
    check("mrst_addr",       bus.ram_addr, 9'h000);
    #2;
    bus.scr_valid = 1'b0;
    rstn = 1'b1;
    step();
    step();
    step();
    check("post_rst_level", bus.cpu_fifo_level, 0);
    check("post_rst_addr",  bus.ram_addr, 9'h000);
    check("post_rst_we",    bus.ram_name_we, 4'h0);
    check("post_rst_busy",  bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
